// File: rtl/life_array_grid.sv
// Parametrised Game-of-Life (B3/S23) array with row load/readout, optional torus wrap,
// free-running generation timer, generation counter and still-life / period-2 detection.
module life_array_grid #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned HEIGHT    = 8,
  parameter int unsigned AW        = $clog2(HEIGHT),
  parameter int unsigned PW        = 16,
  parameter int unsigned GW        = 16,
  parameter bit          AUTO_HALT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_row,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [AW-1:0]     rd_row,
  output logic [WIDTH-1:0]  rd_data,
  output logic [WIDTH-1:0]  rd_data_prev,
  input  logic              wrap,
  input  logic [WIDTH-1:0]  n,
  input  logic [WIDTH-1:0]  s,
  input  logic [HEIGHT-1:0] w,
  input  logic [HEIGHT-1:0] e,
  input  logic              nw,
  input  logic              ne,
  input  logic              sw,
  input  logic              se,
  input  logic              step,
  input  logic              run,
  input  logic [PW-1:0]     period,
  output logic [GW-1:0]     gen_count,
  output logic              still,
  output logic              osc2,
  output logic              running,
  output logic              halted
);

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_t;

  logic [HEIGHT-1:0][WIDTH-1:0]   cur_q, prev_q, prev2_q, next_grid;
  logic [HEIGHT+1:0][WIDTH+1:0]   ext;
  state_t                         state_q;
  logic [PW-1:0]                  cnt_q, per_m1;
  logic [GW-1:0]                  gen_q;
  logic                           still_q, osc2_q;
  logic                           wr_hit, rd_hit, cnt_hit, adv, still_d, osc2_d;

  function automatic logic [3:0] pop8(input logic [7:0] v);
    logic [3:0] sum;
    sum = '0;
    for (int i = 0; i < 8; i++) sum = sum + {3'b000, v[i]};
    return sum;
  endfunction

  // Out-of-range rows are neither writable nor readable.
  assign wr_hit = wr_en && ({1'b0, wr_row} < (AW+1)'(HEIGHT));
  assign rd_hit = {1'b0, rd_row} < (AW+1)'(HEIGHT);

  assign rd_data      = rd_hit ? cur_q[rd_row]  : '0;
  assign rd_data_prev = rd_hit ? prev_q[rd_row] : '0;

  // A period of 0 behaves as 1; >= lets a shortened period fire at the next comparison.
  assign per_m1  = (period == '0) ? '0 : period - 1'b1;
  assign cnt_hit = cnt_q >= per_m1;

  // Grid padded by one cell on every side: wrapped copy of the far edge, or the edge ports.
  always_comb begin
    ext = '0;
    for (int r = 0; r < HEIGHT; r++) begin
      for (int c = 0; c < WIDTH; c++) ext[r+1][c+1] = cur_q[r][c];
    end
    if (wrap) begin
      for (int c = 0; c < WIDTH; c++) begin
        ext[0][c+1]        = cur_q[HEIGHT-1][c];
        ext[HEIGHT+1][c+1] = cur_q[0][c];
      end
      for (int r = 0; r < HEIGHT; r++) begin
        ext[r+1][0]       = cur_q[r][WIDTH-1];
        ext[r+1][WIDTH+1] = cur_q[r][0];
      end
      ext[0][0]              = cur_q[HEIGHT-1][WIDTH-1];
      ext[0][WIDTH+1]        = cur_q[HEIGHT-1][0];
      ext[HEIGHT+1][0]       = cur_q[0][WIDTH-1];
      ext[HEIGHT+1][WIDTH+1] = cur_q[0][0];
    end else begin
      for (int c = 0; c < WIDTH; c++) begin
        ext[0][c+1]        = n[c];
        ext[HEIGHT+1][c+1] = s[c];
      end
      for (int r = 0; r < HEIGHT; r++) begin
        ext[r+1][0]       = w[r];
        ext[r+1][WIDTH+1] = e[r];
      end
      ext[0][0]              = nw;
      ext[0][WIDTH+1]        = ne;
      ext[HEIGHT+1][0]       = sw;
      ext[HEIGHT+1][WIDTH+1] = se;
    end
  end

  for (genvar r = 0; r < HEIGHT; r++) begin : g_row
    for (genvar c = 0; c < WIDTH; c++) begin : g_col
      logic [3:0] cnt;
      assign cnt = pop8({ext[r][c],   ext[r][c+1],   ext[r][c+2],
                         ext[r+1][c],                ext[r+1][c+2],
                         ext[r+2][c], ext[r+2][c+1], ext[r+2][c+2]});
      assign next_grid[r][c] = (cnt == 4'd3) || (cur_q[r][c] && (cnt == 4'd2));
    end
  end

  assign still_d = (next_grid == cur_q);
  assign osc2_d  = (next_grid == prev_q) && !still_d;

  // Decide whether this edge produces a new generation; a write always wins.
  always_comb begin
    adv = 1'b0;
    if (!wr_hit) begin
      case (state_q)
        StIdle:  adv = step;
        StRun:   adv = run && cnt_hit;
        default: adv = 1'b0;
      endcase
    end
  end

  // Grids, counters, flags and run/halt state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q   <= '0;
      prev_q  <= '0;
      prev2_q <= '0;
      gen_q   <= '0;
      still_q <= 1'b0;
      osc2_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= StIdle;
    end else if (wr_hit) begin
      cur_q[wr_row]   <= wr_data;
      prev_q[wr_row]  <= wr_data;
      prev2_q[wr_row] <= '0;
      gen_q           <= '0;
      still_q         <= 1'b0;
      osc2_q          <= 1'b0;
      cnt_q           <= '0;
      state_q         <= run ? StRun : StIdle;
    end else begin
      if (adv) begin
        prev2_q <= prev_q;
        prev_q  <= cur_q;
        cur_q   <= next_grid;
        if (gen_q != {GW{1'b1}}) gen_q <= gen_q + 1'b1;
        still_q <= still_d;
        osc2_q  <= osc2_d;
      end
      case (state_q)
        StIdle: begin
          if (run) begin
            state_q <= StRun;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          if (!run) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_hit) begin
            cnt_q <= '0;
            if (AUTO_HALT && (still_d || osc2_d)) state_q <= StHalted;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHalted: begin
          if (!run) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gen_count = gen_q;
  assign still     = still_q;
  assign osc2      = osc2_q;
  assign running   = (state_q == StRun);
  assign halted    = (state_q == StHalted);

endmodule

// File: doc/life_array_grid.md
Name: life_array_grid

Overview:
- Parametrised WIDTH x HEIGHT Conway Game-of-Life array (rule B3/S23) with row-addressed load and readout.
- Successor to the fixed 8x8 tiled array. Adds the following:
  - generic dimensions;
  - a selectable toroidal-wrap mode;
  - a free-running generation timer with run/halt state machine;
  - a generation counter;
  - still-life and period-2 oscillation detection.
- Sits between the host/display controller and the board edge logic. Larger boards chain instances through the edge ports with wrap=0.

Parameters:
- WIDTH, 8, cells per row (>=3).
- HEIGHT, 8, rows (>=3).
- AW, $clog2(HEIGHT), row address width.
- PW, 16, width of the run-period counter.
- GW, 16, width of the generation counter.
- AUTO_HALT, 1, when 1, RUN stops automatically on still life or period-2 oscillation.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write wr_data into row wr_row this cycle.
- wr_row  in  AW  row to write (0 = top).
- wr_data  in  WIDTH  row contents; bit i = column i (bit 0 = west).
- rd_row  in  AW  row to read.
- rd_data  out  WIDTH  current generation of rd_row (combinational).
- rd_data_prev  out  WIDTH  previous generation of rd_row (combinational).
- wrap  in  1  1 = toroidal neighbours; edge inputs ignored.
- n  in  WIDTH  cells above row 0.
- s  in  WIDTH  cells below row HEIGHT-1.
- w  in  HEIGHT  cells left of column 0.
- e  in  HEIGHT  cells right of column WIDTH-1.
- nw, ne, sw, se  in  1  diagonal corner neighbours.
- step  in  1  advance one generation (honoured in IDLE only).
- run  in  1  level; enables free-running mode.
- period  in  PW  clock cycles per generation in RUN (0 treated as 1).
- gen_count  out  GW  generations since last reset/write, saturating.
- still  out  1  last generation equalled its predecessor.
- osc2  out  1  last generation equalled gen-2 but not gen-1.
- running  out  1  state == RUN.
- halted  out  1  state == HALTED.

Behaviour:
- Reset (async):
  - cur, prev and prev2 grids = 0; gen_count = 0; still = osc2 = 0.
  - State = IDLE; period counter = 0.
  - rd_data and rd_data_prev read 0.
- Advance (one clock edge):
  - next = B3/S23 over the 8 neighbours of each cell.
  - With wrap=0, off-grid neighbours come from n/s/e/w/corners: w[r] is left of row r; n[c] is above column c; nw is above-left of (0,0).
  - With wrap=1, indices are taken mod WIDTH/HEIGHT.
  - On the edge: prev2 <= prev; prev <= cur; cur <= next.
  - gen_count += 1, saturating at 2^GW-1.
  - still <= (next == cur); osc2 <= (next == prev) && !(next == cur).
- Write:
  - wr_en=1 sets cur[wr_row] and prev[wr_row] to wr_data; prev2[wr_row] is cleared.
  - Also clears gen_count, still and osc2, and reloads the period counter.
  - Write has priority: no advance occurs in the same cycle as a write.
- States:
  - IDLE:
    - step=1 (and wr_en=0) -> one advance per cycle step is high.
    - run=1 -> RUN, period counter = 0.
  - RUN:
    - Counter increments each cycle; at max(period,1)-1 it advances and the counter returns to 0.
    - step is ignored.
    - run=0 -> IDLE next cycle, with no partial generation.
    - If AUTO_HALT=1 and an advance sets still or osc2 -> HALTED.
  - HALTED:
    - No advances; step is ignored.
    - run=0 -> IDLE.
    - A write -> RUN if run=1 (flags cleared), otherwise IDLE.
- Latency: every state, flag and grid change is visible the cycle after the triggering edge. Readout is combinational from the registers.
- Boundary rules:
  - period changes mid-count take effect at the next comparison.
  - rd_row/wr_row >= HEIGHT: reads return 0, writes are ignored.
  - Reset mid-RUN returns to IDLE immediately.

Test Plan:
- Single cell: write row0=0x01, step 1 cycle -> rd_data row0=0x00, rd_data_prev row0=0x01, gen_count=1. Step again -> still=1.
- Blinker (wrap=0, edges 0): rows2..4=0x00,0x1C,0x00; step -> rows2..4=0x08,0x08,0x08, osc2=0. Step -> row3=0x1C, osc2=1, still=0.
- Edge spawn (wrap=0): n=e=s=w=0x81, corners=1, step:
  - row0=0x81 and row7=0x81; all other rows 0.
  - This gives one live cell at each of the 4 corners, each born from 3 edge neighbours.
- Wrap glider (wrap=1): rows0..2=0x02,0x04,0x07; run=1, period=1, AUTO_HALT=0 instance. After 32 generations:
  - grid equals the initial pattern;
  - gen_count=32;
  - still and osc2 never set.
- Auto-halt: block rows3..4=0x18, run=1, period=3:
  - first advance exactly 3 cycles after RUN entry;
  - still=1, halted=1, gen_count=1, and no further advance over 20 cycles.
  - Then run=0 -> IDLE.
- Priority/reset: wr_en and step together -> row written, gen_count=0, no advance. Reset asserted mid-RUN -> all rows 0, running=0 on the same edge.
